// File: rtl/result_serializer.sv
// Result serializer: captures left/right result words on each rising edge of outReadyToTB and
// shifts them out MSB first with a one-cycle frame marker, backed by a one-deep holding buffer.
module result_serializer #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned CNT_W = 6
) (
    input  logic             sClk,
    input  logic             reset,
    input  logic [WIDTH-1:0] outDataL,
    input  logic [WIDTH-1:0] outDataR,
    input  logic             outReadyToTB,
    input  logic             clearOverrun,
    output logic             serialL,
    output logic             serialR,
    output logic             frame,
    output logic             busy,
    output logic             pending,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} stateT;

    stateT            state;
    logic             readyQ;
    logic [WIDTH-1:0] shiftL;
    logic [WIDTH-1:0] shiftR;
    logic [WIDTH-1:0] bufL;
    logic [WIDTH-1:0] bufR;
    logic [CNT_W-1:0] cnt;

    logic rise;
    logic lastBit;
    logic dropPair;

    assign rise     = outReadyToTB & ~readyQ;
    assign lastBit  = (state == StShift) && (cnt == '0);
    // On the final bit the buffer drains into the shifter, so a full buffer can still accept.
    assign dropPair = rise && (state == StShift) && !lastBit && pending;

    always_ff @(posedge sClk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            readyQ  <= 1'b0;
            shiftL  <= '0;
            shiftR  <= '0;
            bufL    <= '0;
            bufR    <= '0;
            cnt     <= '0;
            serialL <= 1'b0;
            serialR <= 1'b0;
            frame   <= 1'b0;
            busy    <= 1'b0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            readyQ <= outReadyToTB;

            // Set takes priority over clear.
            if (clearOverrun) begin
                overrun <= 1'b0;
            end
            if (dropPair) begin
                overrun <= 1'b1;
            end

            case (state)
                StIdle: begin
                    serialL <= 1'b0;
                    serialR <= 1'b0;
                    frame   <= 1'b0;
                    busy    <= 1'b0;
                    if (rise) begin
                        shiftL <= outDataL;
                        shiftR <= outDataR;
                        cnt    <= CNT_TOP;
                        state  <= StShift;
                    end
                end

                StShift: begin
                    serialL <= shiftL[WIDTH-1];
                    serialR <= shiftR[WIDTH-1];
                    frame   <= (cnt == CNT_TOP);
                    busy    <= 1'b1;
                    if (!lastBit) begin
                        shiftL <= shiftL << 1;
                        shiftR <= shiftR << 1;
                        cnt    <= cnt - 1'b1;
                        if (rise && !pending) begin
                            bufL    <= outDataL;
                            bufR    <= outDataR;
                            pending <= 1'b1;
                        end
                    end else if (pending) begin
                        shiftL <= bufL;
                        shiftR <= bufR;
                        cnt    <= CNT_TOP;
                        if (rise) begin
                            bufL <= outDataL;
                            bufR <= outDataR;
                        end else begin
                            pending <= 1'b0;
                        end
                    end else if (rise) begin
                        shiftL <= outDataL;
                        shiftR <= outDataR;
                        cnt    <= CNT_TOP;
                    end else begin
                        shiftL <= '0;
                        shiftR <= '0;
                        state  <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule
